instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage in front of instruction_mem. Holds the program counter and drives
//   instruction_address from it. Captures instruction_data, which instruction_mem
//   returns combinationally in the same cycle, into an output register.
//   Hands {instr, pc} to the decode stage over a valid/ready handshake.
//   Supports redirect (branch/jump) with flush, and an optional halt-opcode stop.
// PARAMETERS
//   ADDR_W       8          PC / instruction_address width (256-entry memory)
//   INSTR_W      8          instruction width
//   RESET_PC     8'h00      PC value after reset
//   HALT_OPCODE  8'hFF      encoding that stops fetch (used only with FETCH_HALT_DETECT_EN)
//   CNT_W        16         width of the retired-fetch counter
// PORTS
//   clk                  in   1        single clock, rising edge
//   rst_n                in   1        asynchronous, active-low reset
//   fetch_en             in   1        1 = fetch allowed; 0 = no new capture
//   redirect_valid       in   1        load redirect_pc, flush output register
//   redirect_pc          in   ADDR_W   redirect target
//   instruction_address  out  ADDR_W   to instruction_mem; always equals pc_q
//   instruction_data     in   INSTR_W  from instruction_mem, same cycle
//   if_valid             out  1        output register holds an instruction
//   if_instr             out  INSTR_W  captured instruction
//   if_pc                out  ADDR_W   address it was fetched from
//   id_ready             in   1        decode accepts when if_valid && id_ready
//   halted               out  1        fetch stopped on HALT_OPCODE
//   fetch_count          out  CNT_W    count of accepted handshakes
// BEHAVIOUR
//   Reset (async assert, sync release): pc_q=RESET_PC, if_valid=0, if_instr=0,
//     if_pc=0, halted=0, fetch_count=0, state=RUN.
//   instruction_address = pc_q, combinational. Latency: address-to-if_valid is 1 cycle.
//   load = fetch_en && !halted && (!if_valid || id_ready).
//   Priority per cycle, highest first:
//     1 redirect_valid: pc_q<=redirect_pc, if_valid<=0, halted<=0, state<=RUN.
//       Nothing is captured that cycle. A handshake in that same cycle still counts.
//     2 load: if_instr<=instruction_data, if_pc<=pc_q, if_valid<=1,
//       pc_q<=pc_q+1 modulo 2^ADDR_W (8'hFF -> 8'h00, no flag).
//     3 if_valid && id_ready && !load: if_valid<=0 (drain).
//     4 otherwise: if_instr, if_pc and pc_q hold. Stall: if_valid && !id_ready.
//   if_instr/if_pc stay stable while if_valid && !id_ready. No instruction is lost
//     or duplicated. Back-to-back throughput is 1 per cycle with id_ready held high.
//   fetch_count += 1 on every if_valid && id_ready cycle; wraps at 2^CNT_W.
//   States: RUN (fetching), STALL (if_valid && !id_ready), HALTED.
//     Transitions: RUN->STALL when id_ready is low with data held.
//     STALL->RUN on acceptance.
//     Any state -> RUN on redirect_valid.
//     RUN -> HALTED on halt capture (only with FETCH_HALT_DETECT_EN).
//   fetch_en=0 mid-stream: the held instruction can still be accepted; pc_q holds.
// CONFIGURATION
//   `define FETCH_HALT_DETECT_EN:
//     - When load captures instruction_data==HALT_OPCODE, the halt word is presented
//       normally and halted<=1. pc_q is NOT incremented: it stays at the halt address.
//     - Halted: no loads. if_valid drains after acceptance. Cleared only by
//       redirect_valid or reset.
//   Without the macro: HALT_OPCODE is ignored, halted is tied to 0, state HALTED is
//     unreachable, and fetch runs continuously.
// STRUCTURE
//   Package fetch_pkg holds:
//     - ADDR_W, INSTR_W, RESET_PC, HALT_OPCODE defaults
//     - fetch_state_t enum {RUN, STALL, HALTED}
//     - the handshake struct {instr, pc}, shared with decode
//   One sub-module: fetch_pc_reg. It holds the PC register with async reset,
//     redirect load and increment enable; the top handles handshake and state.
// TESTING
//   - Reset then fetch_en=1, id_ready=1, mem[0..3]=8'h11,22,33,44 ->
//     if_instr 11,22,33,44 on consecutive cycles, if_pc 0..3, fetch_count=4.
//   - Hold id_ready=0 for 3 cycles after first capture ->
//     if_instr=8'h11 and if_pc=0 stable, instruction_address held at 1,
//     no skipped/duplicated word after release.
//   - redirect_valid with redirect_pc=8'h80 while stalled ->
//     next cycle if_valid=0 and instruction_address=8'h80;
//     following capture has if_pc=8'h80.
//   - pc_q=8'hFF with id_ready=1 -> capture from FF, then instruction_address=8'h00;
//     no X or glitch.
//   - FETCH_HALT_DETECT_EN, mem[5]=8'hFF ->
//     halt word presented with if_pc=5, halted=1, instruction_address stays 5,
//     no further if_valid. Redirect to 8'h00 resumes fetch.
//   - Assert rst_n=0 mid-stall -> all outputs at reset values immediately
//     (asynchronously), and fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: default widths, fetch FSM states and the
// {instr, pc} packet handed from fetch to decode.
package fetch_pkg;

  localparam int             ADDR_W_DEF      = 8;
  localparam int             INSTR_W_DEF     = 8;
  localparam int             CNT_W_DEF       = 16;
  localparam logic [7:0]     RESET_PC_DEF    = 8'h00;
  localparam logic [7:0]     HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, redirect load has priority
// over the modulo-2^ADDR_W increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives instruction_address from the PC, registers the returned
// word with a valid/ready handshake to decode. Halt-opcode stop: FETCH_HALT_DETECT_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = ADDR_W_DEF,
  parameter int                 INSTR_W     = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC    = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int                 CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  instruction_address,
  input  logic [INSTR_W-1:0] instruction_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q;
  logic              accept;
  logic              load;
  logic              halt_hit;
  logic              pc_inc;

  assign accept = if_valid && id_ready;
  assign load   = fetch_en && (state != HALTED) && (!if_valid || id_ready);

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = load && (instruction_data == HALT_OPCODE);
  assign halted   = (state == HALTED);
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // A captured halt word leaves the PC parked on the halt address.
  assign pc_inc              = load && !halt_hit && !redirect_valid;
  assign instruction_address = pc_q;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .inc         (pc_inc),
    .pc          (pc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      state    <= RUN;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      state    <= RUN;
    end else if (load) begin
      if_instr <= instruction_data;
      if_pc    <= pc_q;
      if_valid <= 1'b1;
      state    <= halt_hit ? HALTED : RUN;
    end else begin
      if (accept) begin
        if_valid <= 1'b0;
      end
      if (state == HALTED) begin
        state <= HALTED;
      end else if (if_valid && !id_ready) begin
        state <= STALL;
      end else begin
        state <= RUN;
      end
    end
  end

  // Handshakes are counted even when a redirect flushes in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (accept) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed phases push expected
// {instr, pc} handshakes; a negedge monitor pops and compares on each accept.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  instruction_address;
  logic [7:0]  instruction_data;
  logic        if_valid;
  logic [7:0]  if_instr;
  logic [7:0]  if_pc;
  logic        id_ready;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign instruction_data = mem[instruction_address];

  instruction_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .if_valid            (if_valid),
    .if_instr            (if_instr),
    .if_pc               (if_pc),
    .id_ready            (id_ready),
    .halted              (halted),
    .fetch_count         (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] instr, input logic [7:0] pc);
    exp_q.push_back({instr, pc});
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", {if_instr, if_pc}, 32'hDEAD);
      end else begin
        check("handshake", {if_instr, if_pc}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    mem[8'h80] = 8'hC0; mem[8'h81] = 8'hC1;
    mem[8'hFE] = 8'hEE; mem[8'hFF] = 8'h5A;

    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; id_ready = 1'b0;
    #12;
    check("rst_if_valid", if_valid, 0);
    check("rst_addr", instruction_address, 8'h00);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_count", fetch_count, 0);
    check("rst_halted", halted, 0);
    @(negedge clk); rst_n = 1'b1;

    // Streaming 11,22,33,44 back to back.
    tick();
    push(8'h11, 8'h00); push(8'h22, 8'h01); push(8'h33, 8'h02); push(8'h44, 8'h03);
    fetch_en = 1'b1; id_ready = 1'b1;
    repeat (4) tick();
    fetch_en = 1'b0;
    tick();
    check("stream_count", fetch_count, 4);
    check("stream_drained", if_valid, 0);
    check("stream_addr", instruction_address, 8'h04);

    // Stall with 55 held for 3 cycles.
    fetch_en = 1'b1; id_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stall_instr", if_instr, 8'h55);
      check("stall_pc", if_pc, 8'h04);
      check("stall_addr", instruction_address, 8'h05);
      check("stall_valid", if_valid, 1);
      tick();
    end
    push(8'h55, 8'h04); push(8'h66, 8'h05);
    id_ready = 1'b1;
    tick(); tick();
    id_ready = 1'b0;
    check("held77_instr", if_instr, 8'h77);

    // Redirect while stalled flushes 77.
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", if_valid, 0);
    check("redir_addr", instruction_address, 8'h80);
    push(8'hC0, 8'h80); push(8'hC1, 8'h81);
    id_ready = 1'b1;
    tick(); tick();
    fetch_en = 1'b0;
    tick();
    check("redir_count", fetch_count, 8);

    // PC wrap FE -> FF -> 00.
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    push(8'hEE, 8'hFE); push(8'h5A, 8'hFF); push(8'h11, 8'h00);
    tick(); tick();
    check("wrap_addr", instruction_address, 8'h00);
    check("wrap_addr_known", $isunknown(instruction_address), 0);
    tick();
    fetch_en = 1'b0;
    tick();
    check("wrap_count", fetch_count, 11);

    // Halt opcode at address 5.
    mem[5] = 8'hFF;
    redirect_valid = 1'b1; redirect_pc = 8'h04;
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
    push(8'h55, 8'h04); push(8'hFF, 8'h05);
    tick(); tick();
    check("halt_flag", halted, 1);
    check("halt_addr", instruction_address, 8'h05);
    check("halt_word_pc", if_pc, 8'h05);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("halt_no_valid", if_valid, 0);
      check("halt_addr_hold", instruction_address, 8'h05);
      tick();
    end
    check("halt_count", fetch_count, 13);
`else
    push(8'h55, 8'h04); push(8'hFF, 8'h05); push(8'h77, 8'h06);
    tick(); tick(); tick();
    fetch_en = 1'b0;
    tick();
    check("nohalt_flag", halted, 0);
    check("nohalt_addr", instruction_address, 8'h07);
    check("nohalt_count", fetch_count, 14);
    fetch_en = 1'b1;
`endif
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", halted, 0);
    push(8'h11, 8'h00);
    tick();
    fetch_en = 1'b0;
    tick();
`ifdef FETCH_HALT_DETECT_EN
    check("resume_count", fetch_count, 14);
`else
    check("resume_count", fetch_count, 15);
`endif

    // Async reset in the middle of a stall.
    fetch_en = 1'b1; id_ready = 1'b0;
    tick();
    check("prerst_valid", if_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", if_valid, 0);
    check("arst_addr", instruction_address, 8'h00);
    check("arst_instr", if_instr, 0);
    check("arst_pc", if_pc, 0);
    check("arst_count", fetch_count, 0);
    check("arst_halted", halted, 0);
    @(negedge clk); rst_n = 1'b1;
    push(8'h11, 8'h00);
    id_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    check("postrst_count", fetch_count, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
